slot_mem_arbiter: RTL and testbench

- Parametrised successor to the fixed two-port cartridge memory fan-out.
- Lets CHANNELS cartridge/mapper engines share one external SDRAM port through a round-robin arbiter.
- Each channel gets its own address region and a level-style ready/busy handshake toward its mapper.
- A per-channel enable mask turns a channel into an idle stub: ready=1, dout=FF, requests ignored. This is for memory configurations that cannot back that channel.

---
 rtl/slot_mem_arbiter_pkg.sv | 10 +
 rtl/slot_mem_arbiter_rr_pick.sv | 19 +
 rtl/slot_mem_arbiter.sv | 95 +++++++++
 tb/tb_slot_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_mem_arbiter_pkg.sv
// slot_pkg: arbiter FSM state type, default sizes and {index, local} address builder
package slot_pkg;
  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_REGION_BITS = 3;
  localparam int DEF_DATA_W = 8;
  function automatic logic [31:0] mk_addr(input logic [31:0] idx, input logic [31:0] loc, input int loc_w);
    return (idx << loc_w) | (loc & ((32'd1 << loc_w) - 32'd1));
  endfunction
endpackage

// File: rtl/slot_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick; req mask + ptr in, first req at/after ptr (with wrap) out as gnt, vld = any req
module rr_pick #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt,
  output logic         vld
);
  logic [N-1:0] rot;
  always_comb begin
    rot = N'({req, req} >> ptr);
    gnt = '0;
    vld = |req;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) gnt = W'((int'(ptr) + j) % N);
  end
endmodule

// File: rtl/slot_mem_arbiter.sv
// slot_mem_arbiter: CHANNELS level-handshake channels (ch_*) share one SDRAM port (mem_*) via round-robin; busy_ch = current grant
module slot_mem_arbiter
  import slot_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int ADDR_W      = 25,
  parameter int REGION_BITS = DEF_REGION_BITS,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [CHANNELS-1:0]          ch_en,
  input  logic [CHANNELS-1:0]          ch_rd,
  input  logic [CHANNELS-1:0]          ch_we,
  input  logic [CHANNELS*ADDR_W-1:0]   ch_addr,
  input  logic [CHANNELS*DATA_W-1:0]   ch_din,
  output logic [CHANNELS*DATA_W-1:0]   ch_dout,
  output logic [CHANNELS-1:0]          ch_ready,
  output logic [CHANNELS-1:0]          ch_overrun,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_din,
  input  logic [DATA_W-1:0]            mem_dout,
  input  logic                         mem_done,
  output logic [REGION_BITS-1:0]       busy_ch
);
  localparam int LOC_W = ADDR_W - REGION_BITS;
  localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  arb_state_t state;
  logic [CHANNELS-1:0] prev_lvl, pending, cap_we, lvl, rise;
  logic [CHANNELS-1:0][ADDR_W-1:0] cap_addr;
  logic [CHANNELS-1:0][DATA_W-1:0] cap_din, dout_q;
  logic [REGION_BITS-1:0] ptr, gnt;
  logic vld;
  logic [IW-1:0] gi, bi;
  assign lvl = ch_rd | ch_we;
  assign rise = lvl & ~prev_lvl & ch_en;
  assign ch_ready = ~pending | ~ch_en;
  assign gi = gnt[IW-1:0];
  assign bi = busy_ch[IW-1:0];
  for (genvar i = 0; i < CHANNELS; i++) begin : g_dout
    assign ch_dout[i*DATA_W +: DATA_W] = ch_en[i] ? dout_q[i] : '1;
  end
  rr_pick #(.N(CHANNELS), .W(REGION_BITS)) u_pick (
    .req(pending),
    .ptr(ptr),
    .gnt(gnt),
    .vld(vld)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      prev_lvl   <= '0;
      pending    <= '0;
      cap_we     <= '0;
      cap_addr   <= '0;
      cap_din    <= '0;
      dout_q     <= '1;
      ch_overrun <= '0;
      ptr        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      busy_ch    <= '0;
    end else begin
      prev_lvl   <= lvl;
      ch_overrun <= ch_overrun | (rise & pending);
      mem_req    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++)
        if (rise[i] && !pending[i]) begin
          pending[i]  <= 1'b1;
          cap_we[i]   <= ch_we[i];
          cap_addr[i] <= ch_addr[i*ADDR_W +: ADDR_W];
          cap_din[i]  <= ch_din[i*DATA_W +: DATA_W];
        end
      if (state == ARB_IDLE) begin
        if (vld) begin
          mem_req  <= 1'b1;
          mem_we   <= cap_we[gi];
          mem_din  <= cap_din[gi];
          mem_addr <= ADDR_W'(mk_addr(32'(gnt), 32'(cap_addr[gi]), LOC_W));
          busy_ch  <= gnt;
          state    <= ARB_WAIT;
        end
      end else if (mem_done) begin
        if (!cap_we[bi] && ch_en[bi]) dout_q[bi] <= mem_dout;
        pending[bi] <= 1'b0;
        ptr   <= (busy_ch == REGION_BITS'(CHANNELS - 1)) ? '0 : busy_ch + 1'b1;
        state <= ARB_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_slot_mem_arbiter.sv
// tb_slot_mem_arbiter: table vectors, directed corner sequences and random traffic against a cycle-level reference model
module tb_slot_mem_arbiter;
  localparam int C = 4, AW = 25, RB = 3, DW = 8, LOC = AW - RB;
  logic clk = 0, reset_n = 0;
  logic [C-1:0] ch_en = '1, ch_rd = '0, ch_we = '0;
  logic [C*AW-1:0] ch_addr = '0;
  logic [C*DW-1:0] ch_din = '0, ch_dout;
  logic [C-1:0] ch_ready, ch_overrun;
  logic mem_req, mem_we, mem_done = 0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout = '0;
  logic [RB-1:0] busy_ch;
  slot_mem_arbiter #(.CHANNELS(C), .ADDR_W(AW), .REGION_BITS(RB), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .ch_rd(ch_rd), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_din(ch_din), .ch_dout(ch_dout), .ch_ready(ch_ready),
    .ch_overrun(ch_overrun), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_done(mem_done), .busy_ch(busy_ch)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cnt = 0, lat = 2, nreq = 0;
  bit auto_mem = 1, rnd_lat = 0, use_fixed = 0, spur = 0;
  logic [7:0] fixed = 8'h00, rdata = 8'h00;
  logic [C-1:0] m_pend, m_prev, m_ovr, m_we;
  int unsigned m_addr[C], m_din[C], m_dout[C];
  int m_ptr, m_g, m_bch;
  bit m_busy, m_req, m_mwe;
  int unsigned m_maddr, m_mdin;
  int grants[$];
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_ovr = '0; m_we = '0;
    m_ptr = 0; m_g = 0; m_bch = 0; m_busy = 0; m_req = 0; m_mwe = 0; m_maddr = 0; m_mdin = 0;
    for (int i = 0; i < C; i++) begin m_addr[i] = 0; m_din[i] = 0; m_dout[i] = 8'hFF; end
  endtask
  task automatic model_step();
    logic [C-1:0] old_pend, lvl;
    bit found;
    if (!reset_n) begin model_reset(); return; end
    old_pend = m_pend;
    lvl = ch_rd | ch_we;
    m_req = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < C; k++)
        if (!found && old_pend[(m_ptr + k) % C]) begin found = 1; m_g = (m_ptr + k) % C; end
      if (found) begin
        m_busy = 1; m_req = 1; m_bch = m_g;
        m_maddr = m_g * (1 << LOC) + m_addr[m_g] % (1 << LOC);
        m_mwe = m_we[m_g];
        m_mdin = m_din[m_g];
      end
    end else if (mem_done) begin
      if (!m_we[m_g] && ch_en[m_g]) m_dout[m_g] = mem_dout;
      m_pend[m_g] = 0;
      m_ptr = (m_g + 1) % C;
      m_busy = 0;
    end
    for (int i = 0; i < C; i++)
      if (lvl[i] && !m_prev[i] && ch_en[i]) begin
        if (old_pend[i]) m_ovr[i] = 1;
        else begin
          m_pend[i] = 1; m_we[i] = ch_we[i];
          m_addr[i] = ch_addr[i*AW +: AW]; m_din[i] = ch_din[i*DW +: DW];
        end
      end
    m_prev = lvl;
  endtask
  task automatic compare();
    logic [C-1:0] er;
    logic [C*DW-1:0] ed;
    for (int i = 0; i < C; i++) begin
      er[i] = !m_pend[i] || !ch_en[i];
      ed[i*DW +: DW] = ch_en[i] ? DW'(m_dout[i]) : 8'hFF;
    end
    chk("mem_req", 64'(mem_req), 64'(m_req));
    chk("mem_we", 64'(mem_we), 64'(m_mwe));
    chk("mem_addr", 64'(mem_addr), 64'(m_maddr));
    chk("mem_din", 64'(mem_din), 64'(m_mdin));
    chk("busy_ch", 64'(busy_ch), 64'(m_bch));
    chk("ch_ready", 64'(ch_ready), 64'(er));
    chk("ch_dout", 64'(ch_dout), 64'(ed));
    chk("ch_overrun", 64'(ch_overrun), 64'(m_ovr));
  endtask
  task automatic tick();
    mem_done = 0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin mem_done = 1; mem_dout = rdata; end
    end else if (spur && $urandom_range(0, 39) == 0) begin
      mem_done = 1; mem_dout = 8'($urandom);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (auto_mem && mem_req) begin
      cnt = rnd_lat ? int'($urandom_range(1, 4)) : lat;
      rdata = use_fixed ? fixed : 8'($urandom);
    end
    if (mem_req) nreq++;
    compare();
  endtask
  task automatic do_reset();
    reset_n = 0; ch_rd = '0; ch_we = '0; ch_en = '1; mem_done = 0; cnt = 0; spur = 0; auto_mem = 1;
    #1;
    model_reset();
    tick(); tick();
    reset_n = 1;
    tick();
  endtask
  task automatic collect(input int n);
    for (int t = 0; t < 40 && grants.size() < n; t++) begin
      tick();
      if (mem_req) grants.push_back(int'(busy_ch));
    end
  endtask
  task automatic wait_ready(input logic [C-1:0] m);
    for (int t = 0; t < 40 && (ch_ready & m) != m; t++) tick();
    chk("ready_timeout", 64'(ch_ready & m), 64'(m));
  endtask
  typedef struct {
    logic [3:0] rd;
    logic       ereq;
    logic [3:0] erdy;
    logic [7:0] edout;
    logic       ca;
  } vec_t;
  vec_t tbl[6];
  int r0;
  initial begin
    tbl[0] = '{4'b0000, 1'b0, 4'b1111, 8'hFF, 1'b0};
    tbl[1] = '{4'b0010, 1'b0, 4'b1101, 8'hFF, 1'b0};
    tbl[2] = '{4'b0010, 1'b1, 4'b1101, 8'hFF, 1'b1};
    tbl[3] = '{4'b0010, 1'b0, 4'b1101, 8'hFF, 1'b1};
    tbl[4] = '{4'b0010, 1'b0, 4'b1111, 8'h5A, 1'b1};
    tbl[5] = '{4'b0000, 1'b0, 4'b1111, 8'h5A, 1'b0};
    do_reset();
    chk("rst_ready", 64'(ch_ready), 64'hF);
    chk("rst_dout", 64'(ch_dout), 64'hFFFFFFFF);
    chk("rst_addr", 64'(mem_addr), 64'h0);
    chk("rst_req", 64'(mem_req), 64'h0);
    // single read through the vector table
    ch_addr[1*AW +: AW] = 25'h0123;
    lat = 2; use_fixed = 1; fixed = 8'h5A;
    for (int v = 0; v < 6; v++) begin
      ch_rd = tbl[v].rd;
      tick();
      chk("tbl_req", 64'(mem_req), 64'(tbl[v].ereq));
      chk("tbl_ready", 64'(ch_ready), 64'(tbl[v].erdy));
      chk("tbl_dout1", 64'(ch_dout[15:8]), 64'(tbl[v].edout));
      if (tbl[v].ca) begin
        chk("tbl_addr", 64'(mem_addr), 64'h0400123);
        chk("tbl_we", 64'(mem_we), 64'h0);
      end
    end
    use_fixed = 0;
    // disabled channel is an idle stub
    ch_en[1] = 0;
    tick();
    chk("dis_dout", 64'(ch_dout[15:8]), 64'hFF);
    r0 = nreq;
    ch_rd[1] = 1;
    repeat (5) tick();
    chk("dis_nreq", 64'(nreq - r0), 64'h0);
    chk("dis_ready", 64'(ch_ready[1]), 64'h1);
    ch_rd[1] = 0;
    tick();
    ch_en[1] = 1;
    tick();
    chk("reen_dout", 64'(ch_dout[15:8]), 64'h5A);
    // contention and round-robin wrap
    do_reset();
    lat = 1;
    grants.delete();
    ch_rd = 4'b1101;
    collect(3);
    wait_ready(4'hF);
    ch_rd = '0;
    tick();
    ch_rd = 4'b1001;
    collect(5);
    wait_ready(4'hF);
    chk("rr_count", 64'(grants.size()), 64'd5);
    if (grants.size() == 5) begin
      chk("rr_g0", 64'(grants[0]), 64'd0);
      chk("rr_g1", 64'(grants[1]), 64'd2);
      chk("rr_g2", 64'(grants[2]), 64'd3);
      chk("rr_g3", 64'(grants[3]), 64'd0);
      chk("rr_g4", 64'(grants[4]), 64'd3);
    end
    ch_rd = '0;
    tick();
    // write with rd and we rising together
    do_reset();
    lat = 2;
    ch_addr[3*AW +: AW] = 25'h00AB;
    ch_din[31:24] = 8'hC3;
    ch_rd[3] = 1; ch_we[3] = 1;
    tick();
    for (int t = 0; t < 10 && !mem_req; t++) tick();
    chk("wr_req", 64'(mem_req), 64'h1);
    chk("wr_we", 64'(mem_we), 64'h1);
    chk("wr_din", 64'(mem_din), 64'hC3);
    chk("wr_addr", 64'(mem_addr), 64'hC000AB);
    wait_ready(4'b1000);
    chk("wr_dout", 64'(ch_dout[31:24]), 64'hFF);
    ch_rd = '0; ch_we = '0;
    tick();
    // overrun: second edge while the first is still in flight
    do_reset();
    lat = 4;
    r0 = nreq;
    ch_rd[2] = 1; tick();
    tick();
    ch_rd[2] = 0; tick();
    ch_rd[2] = 1; tick();
    repeat (8) tick();
    chk("ovr_nreq", 64'(nreq - r0), 64'h1);
    chk("ovr_flag", 64'(ch_overrun[2]), 64'h1);
    chk("ovr_ready", 64'(ch_ready[2]), 64'h1);
    // async reset in the middle of WAIT
    do_reset();
    lat = 5;
    ch_rd[0] = 1;
    tick(); tick(); tick();
    chk("mw_pending", 64'(ch_ready[0]), 64'h0);
    reset_n = 0;
    #1;
    chk("mw_req", 64'(mem_req), 64'h0);
    chk("mw_ready", 64'(ch_ready), 64'hF);
    cnt = 0; ch_rd = '0;
    model_reset();
    tick();
    reset_n = 1;
    auto_mem = 0; cnt = 1; rdata = 8'h77;
    tick();
    chk("mw_dout", 64'(ch_dout), 64'hFFFFFFFF);
    tick();
    chk("mw_idle", 64'(mem_req), 64'h0);
    // random traffic against the model
    do_reset();
    rnd_lat = 1; spur = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < C; i++) begin
        if ($urandom_range(0, 5) == 0) ch_rd[i] = ~ch_rd[i];
        if ($urandom_range(0, 11) == 0) ch_we[i] = ~ch_we[i];
        if ($urandom_range(0, 99) == 0) ch_en[i] = ~ch_en[i];
        ch_addr[i*AW +: AW] = AW'($urandom);
        ch_din[i*DW +: DW] = DW'($urandom);
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
